// File: rtl/obuf_pkg.sv
// Shared definitions for the systolic-array output-buffer control path.
// Used by obuf_seq_ctrl and by the array top-level controller.
//   state_t     : sequencer state encoding (IDLE -> LOAD -> DRAIN)
//   LOAD_CYC    : fill-window length for the default array geometry
//   load_cyc_f  : fill-window length for an arbitrary geometry
//   cnt_w       : bit width of a counter that must hold 0 .. max_val
package obuf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int ARRAYWIDTH_DEF = 4;
  localparam int DSP_DELAY_DEF  = 3;
  localparam int LOAD_CYC       = ARRAYWIDTH_DEF * DSP_DELAY_DEF;

  // One column strobe every DSP_DELAY cycles across all columns.
  function automatic int load_cyc_f(input int array_width, input int dsp_delay);
    return array_width * dsp_delay;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/obuf_seq_ctrl.sv
// Sequencer for the systolic-array output buffer.
// On acc_done it opens exactly one continuous load window of LOAD_CYC cycles
// (so the buffer's phase counter finishes back at its reset phase), then
// drains DRAIN_LEN words to the writeback path under valid/ready.
// A result arriving while a tile is still in flight is dropped and flagged.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   acc_done   : 1-cycle pulse, first column valid on the buffer input
//   out_ready  : downstream accepts a word this cycle
//   clr_err    : clears the sticky error flag
//   load_en    : buffer load enable (high for the whole fill window)
//   out_en     : buffer shift-out strobe (valid & ready)
//   out_valid  : buffer output word valid
//   out_last   : current valid word is the tile's last
//   busy       : sequencer not idle
//   done       : 1-cycle pulse after the final drain beat
//   err        : sticky, acc_done received while busy
module obuf_seq_ctrl
  import obuf_pkg::*;
#(
  parameter int ARRAYWIDTH = ARRAYWIDTH_DEF,
  parameter int DSP_DELAY  = DSP_DELAY_DEF,
  parameter int DRAIN_LEN  = ARRAYWIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic acc_done,
  input  logic out_ready,
  input  logic clr_err,
  output logic load_en,
  output logic out_en,
  output logic out_valid,
  output logic out_last,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int LOAD_LEN = load_cyc_f(ARRAYWIDTH, DSP_DELAY);
  localparam int LW       = cnt_w(LOAD_LEN);
  localparam int BW       = cnt_w(DRAIN_LEN);

  localparam logic [LW-1:0] LOAD_TOP   = LW'(LOAD_LEN - 1);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(DRAIN_LEN - 1);
  localparam logic [BW-1:0] BEAT_TERM  = BW'(DRAIN_LEN);

  state_t          state, state_nxt;
  logic [LW-1:0]   load_cnt;
  logic [BW-1:0]   beat_cnt;
  logic            load_end;
  logic            accept;

  assign load_end = (state == ST_LOAD) && (load_cnt == '0);
  assign accept   = (state == ST_IDLE) && acc_done;

  // State register.
  // NOTE: sequential state uses <= so every flop samples pre-edge values;
  // blocking here would make the result depend on process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (acc_done)            state_nxt = ST_LOAD;
      ST_LOAD:  if (load_end)            state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_en && out_last)  state_nxt = ST_IDLE;
      default:                           state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; out_en is the only path that is
  // combinational on an input (out_ready).
  always_comb begin
    load_en   = (state == ST_LOAD);
    out_valid = (state == ST_DRAIN);
    busy      = (state != ST_IDLE);
    out_last  = out_valid && (beat_cnt == BEAT_LAST);
    out_en    = out_valid && out_ready;
  end

  // Load window counter: LOAD_TOP down to 0, holds at 0.
  always_ff @(posedge clk) begin
    if (rst)                                load_cnt <= '0;
    else if (accept)                        load_cnt <= LOAD_TOP;
    else if (state == ST_LOAD && !load_end) load_cnt <= load_cnt - 1'b1;
  end

  // Drain beat counter: cleared on entering DRAIN, steps once per accepted
  // word, saturates at DRAIN_LEN.
  always_ff @(posedge clk) begin
    if (rst)                                  beat_cnt <= '0;
    else if (load_end)                        beat_cnt <= '0;
    else if (out_en && beat_cnt != BEAT_TERM) beat_cnt <= beat_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) done <= 1'b0;
    else     done <= out_en && out_last;
  end

  // A dropped result wins over a same-cycle clear so it is never lost.
  always_ff @(posedge clk) begin
    if (rst)                   err <= 1'b0;
    else if (acc_done && busy) err <= 1'b1;
    else if (clr_err)          err <= 1'b0;
  end

endmodule

// File: tb/tb_obuf_seq_ctrl.sv
// Directed bench for obuf_seq_ctrl (ARRAYWIDTH=4, DSP_DELAY=3, DRAIN_LEN=4).
// Stimulus pushes expected load windows, drain beats and done pulses into
// queues; an independent monitor pops and compares as the DUT produces them.
// Cycle numbers are relative to the most recent reset release.
module tb_obuf_seq_ctrl;

  logic clk = 1'b0;
  logic rst, acc_done, out_ready, clr_err;
  logic load_en, out_en, out_valid, out_last, busy, done, err;

  obuf_seq_ctrl #(.ARRAYWIDTH(4), .DSP_DELAY(3), .DRAIN_LEN(4)) dut (
    .clk(clk), .rst(rst), .acc_done(acc_done), .out_ready(out_ready),
    .clr_err(clr_err), .load_en(load_en), .out_en(out_en),
    .out_valid(out_valid), .out_last(out_last), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  int cyc  = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct { int cyc; int last; } beat_t;
  beat_t beat_q[$];
  int    load_start_q[$];
  int    load_len_q[$];
  int    done_q[$];

  int load_total = 0;
  int load_start = 0;
  logic prev_load = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc - base, act, exp);
    end
  endtask

  // Monitor: compares DUT activity against the scoreboard queues.
  always @(negedge clk) begin
    int t;
    beat_t b;
    t = cyc - base;
    if (load_en && !prev_load) load_start = t;
    if (!load_en && prev_load) begin
      if (load_start_q.size() == 0) check("load_unexpected", load_start, -1);
      else begin
        check("load_start", load_start, load_start_q.pop_front());
        check("load_len", t - load_start, load_len_q.pop_front());
      end
    end
    prev_load = load_en;
    if (load_en) load_total++;
    if (out_en) begin
      if (beat_q.size() == 0) check("beat_unexpected", t, -1);
      else begin
        b = beat_q.pop_front();
        check("beat_cycle", t, b.cyc);
        check("beat_last", int'(out_last), b.last);
      end
    end
    if (done) begin
      if (done_q.size() == 0) check("done_unexpected", t, -1);
      else check("done_cycle", t, done_q.pop_front());
    end
  end

  task automatic goto(input int n);
    while (cyc - base < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic push_load(input int start, input int len);
    load_start_q.push_back(start);
    load_len_q.push_back(len);
  endtask

  task automatic push_beat(input int c, input int last);
    beat_t b;
    b.cyc  = c;
    b.last = last;
    beat_q.push_back(b);
  endtask

  // Unstalled tile for acc_done accepted in cycle a.
  task automatic exp_tile(input int a);
    push_load(a + 1, 12);
    for (int i = 0; i < 4; i++) push_beat(a + 13 + i, (i == 3) ? 1 : 0);
    done_q.push_back(a + 17);
  endtask

  task automatic pulse_acc(input int n);
    goto(n);
    acc_done = 1'b1;
    goto(n + 1);
    acc_done = 1'b0;
  endtask

  int snap;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; acc_done = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    settle();
    check("reset_outputs",
          int'({load_en, out_en, out_valid, out_last, busy, done, err}), 0);

    // 1: basic tile
    exp_tile(10);
    pulse_acc(10);
    goto(26); settle();
    check("t1_busy_26", int'(busy), 1);
    check("t1_last_26", int'(out_last), 1);
    goto(27); settle();
    check("t1_busy_27", int'(busy), 0);
    check("t1_done_27", int'(done), 1);
    goto(35);

    // 2: backpressure in cycles 24-25
    do_reset();
    push_load(11, 12);
    push_beat(23, 0); push_beat(26, 0); push_beat(27, 0); push_beat(28, 1);
    done_q.push_back(29);
    pulse_acc(10);
    goto(24); out_ready = 1'b0; settle();
    check("t2_valid_24", int'(out_valid), 1);
    check("t2_en_24", int'(out_en), 0);
    goto(25); settle();
    check("t2_valid_25", int'(out_valid), 1);
    check("t2_en_25", int'(out_en), 0);
    goto(26); out_ready = 1'b1;
    goto(29); settle();
    check("t2_done_29", int'(done), 1);
    goto(35);

    // 3: overlap during LOAD and on the last beat
    do_reset();
    exp_tile(10);
    pulse_acc(10); settle();
    check("t3_err_11", int'(err), 0);
    pulse_acc(15); settle();
    check("t3_err_16", int'(err), 1);
    pulse_acc(26); settle();
    check("t3_busy_27", int'(busy), 0);
    check("t3_err_27", int'(err), 1);
    goto(30); clr_err = 1'b1; settle();
    check("t3_err_30", int'(err), 1);
    goto(31); clr_err = 1'b0; settle();
    check("t3_err_31", int'(err), 0);
    goto(45);

    // 4: back-to-back, second acc_done in the done cycle
    do_reset();
    snap = load_total;
    exp_tile(10);
    exp_tile(27);
    pulse_acc(10);
    goto(27); settle();
    check("t4_done_27", int'(done), 1);
    pulse_acc(27);
    goto(50); settle();
    check("t4_load_total", load_total - snap, 24);
    check("t4_err", int'(err), 0);

    // 5: reset in LOAD with err already set
    do_reset();
    push_load(11, 8);
    pulse_acc(10);
    pulse_acc(15); settle();
    check("t5_err_16", int'(err), 1);
    goto(18); rst = 1'b1;
    goto(19); rst = 1'b0; settle();
    check("t5_load_19", int'(load_en), 0);
    check("t5_busy_19", int'(busy), 0);
    check("t5_err_19", int'(err), 0);
    exp_tile(25);
    pulse_acc(25);
    goto(50);

    // 6: set beats clear in the same cycle
    do_reset();
    exp_tile(10);
    pulse_acc(10);
    pulse_acc(13); settle();
    check("t6_err_14", int'(err), 1);
    goto(15); acc_done = 1'b1; clr_err = 1'b1;
    goto(16); acc_done = 1'b0; clr_err = 1'b0; settle();
    check("t6_err_16", int'(err), 1);
    goto(17); clr_err = 1'b1;
    goto(18); clr_err = 1'b0; settle();
    check("t6_err_18", int'(err), 0);
    goto(35);

    check("left_loads", load_start_q.size(), 0);
    check("left_beats", beat_q.size(), 0);
    check("left_dones", done_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
